// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared state encoding and size defaults for the instruction-fetch responder
package instr_mem_pkg;
  localparam int ADDRESS_WIDTH_DEF = 3;
  localparam int DATA_WIDTH_DEF    = 8;
  localparam int FETCH_WIDTH       = 2 * DATA_WIDTH_DEF;
  localparam int DEPTH_DEF         = 1 << ADDRESS_WIDTH_DEF;
  localparam logic [ADDRESS_WIDTH_DEF-1:0] ADDR_WRAP_MASK = ADDRESS_WIDTH_DEF'(DEPTH_DEF - 1);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;
endpackage

// File: rtl/instr_byte_store.sv
// rtl/instr_byte_store.sv - byte register array, one synchronous write port, two combinational reads
module instr_byte_store
  import instr_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_lo,
  output logic [DATA_WIDTH-1:0]    rd_data_lo,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_hi,
  output logic [DATA_WIDTH-1:0]    rd_data_hi
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is read-before-write.
  assign rd_data_lo = r_mem[rd_addr_lo];
  assign rd_data_hi = r_mem[rd_addr_hi];
endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - IDLE/WAIT/RESP fetch responder returning {mem[a+1], mem[a]}
// Optional INSTR_MEM_LAST_HIT_EN: one-entry last-address tag lets a repeat fetch skip WAIT.
module instr_mem_responder
  import instr_mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int WAIT_STATES   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [ADDRESS_WIDTH-1:0]  req_addr,
  output logic                      req_ready,
  output logic                      rsp_valid,
  output logic [2*DATA_WIDTH-1:0]   rsp_data,
  input  logic                      rsp_ready,
  input  logic                      load_en,
  input  logic [ADDRESS_WIDTH-1:0]  load_addr,
  input  logic [DATA_WIDTH-1:0]     load_data
);
  localparam logic [2:0] WS_LAST = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_t                    r_state;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [2:0]                r_cnt;
  logic [2*DATA_WIDTH-1:0]   r_rsp_data;
  logic [ADDRESS_WIDTH-1:0]  w_rd_addr;
  logic [ADDRESS_WIDTH-1:0]  w_rd_addr_hi;
  logic [DATA_WIDTH-1:0]     w_rd_lo;
  logic [DATA_WIDTH-1:0]     w_rd_hi;
  logic                      w_accept;
  logic                      w_hit;
  logic                      w_read;

  // With no wait states the read happens at the accept edge, straight off req_addr.
  assign w_rd_addr    = (r_state == ST_IDLE) ? req_addr : r_addr;
  assign w_rd_addr_hi = w_rd_addr + 1'b1;
  assign w_accept     = (r_state == ST_IDLE) && req_valid;
  assign w_read       = (WAIT_STATES == 0) ? (w_accept && !w_hit)
                                           : ((r_state == ST_WAIT) && (r_cnt == WS_LAST));

  instr_byte_store #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (load_en),
    .wr_addr    (load_addr),
    .wr_data    (load_data),
    .rd_addr_lo (w_rd_addr),
    .rd_data_lo (w_rd_lo),
    .rd_addr_hi (w_rd_addr_hi),
    .rd_data_hi (w_rd_hi)
  );

`ifdef INSTR_MEM_LAST_HIT_EN
  logic [ADDRESS_WIDTH-1:0]  r_last_addr;
  logic                      r_last_valid;
  logic                      w_load_clobbers_tag;
  logic                      w_load_clobbers_read;

  assign w_load_clobbers_tag  = load_en && ((load_addr == r_last_addr) ||
                                            (load_addr == r_last_addr + 1'b1));
  assign w_load_clobbers_read = load_en && ((load_addr == w_rd_addr) ||
                                            (load_addr == w_rd_addr_hi));
  assign w_hit = r_last_valid && (req_addr == r_last_addr) && !w_load_clobbers_tag;

  // A load racing the read edge leaves rsp_data stale, so that read must not arm the tag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last_valid <= 1'b0;
      r_last_addr  <= '0;
    end else if (w_read) begin
      r_last_valid <= !w_load_clobbers_read;
      r_last_addr  <= w_rd_addr;
    end else if (w_load_clobbers_tag) begin
      r_last_valid <= 1'b0;
    end
  end
`else
  assign w_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rsp_data <= '0;
    end else begin
      if (w_read) r_rsp_data <= {w_rd_hi, w_rd_lo};
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr;
            r_cnt   <= '0;
            r_state <= (w_hit || (WAIT_STATES == 0)) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == WS_LAST) r_state <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed plus randomized self-checking bench for instr_mem_responder
module tb_instr_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_addr;
  logic        rsp_ready;
  logic        load_en;
  logic [2:0]  load_addr;
  logic [7:0]  load_data;
  logic        req_ready_a, rsp_valid_a, req_ready_b, rsp_valid_b;
  logic [15:0] rsp_data_a, rsp_data_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mem_m [8];
  logic [2:0]  tag_addr;
  bit          tag_valid;

  always #5 clk = ~clk;

  instr_mem_responder #(.WAIT_STATES(1)) u_dut_ws1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a),
    .rsp_ready(rsp_ready), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  instr_mem_responder #(.WAIT_STATES(3)) u_dut_ws3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b),
    .rsp_ready(rsp_ready), .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] word_at(input logic [2:0] a);
    logic [2:0] hi;
    hi = a + 3'd1;
    return {mem_m[hi], mem_m[a]};
  endfunction

  function automatic void model_load(input logic [2:0] a, input logic [7:0] d);
    logic [2:0] nxt;
    nxt = tag_addr + 3'd1;
    mem_m[a] = d;
    if (tag_valid && (a == tag_addr || a == nxt)) tag_valid = 1'b0;
  endfunction

  function automatic bit model_hit(input logic [2:0] a);
`ifdef INSTR_MEM_LAST_HIT_EN
    return tag_valid && (tag_addr == a);
`else
    return (a != a);
`endif
  endfunction

  task automatic do_load(input logic [2:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
    model_load(a, d);
  endtask

  // Accepts one fetch, optionally loads byte a during the first cycle after accept,
  // and checks latency and data of both responders against the model.
  task automatic fetch(input string tag, input logic [2:0] a, input bit mid_ld, input logic [7:0] ld_d);
    int          lat_a, lat_b, exp_lat_a, exp_lat_b;
    logic [15:0] got_a, got_b, old_w, new_w;
    bit          hit;
    lat_a = 0; lat_b = 0; got_a = '0; got_b = '0;
    hit = model_hit(a);
    exp_lat_a = hit ? 1 : 1 + 1;
    exp_lat_b = hit ? 1 : 3 + 1;
    old_w = word_at(a);
    check({tag, " req_ready_a"}, 32'(req_ready_a), 32'd1);
    check({tag, " req_ready_b"}, 32'(req_ready_b), 32'd1);
    req_valid = 1'b1; req_addr = a; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (rsp_valid_a && lat_a == 0) begin lat_a = k; got_a = rsp_data_a; end
      if (rsp_valid_b && lat_b == 0) begin lat_b = k; got_b = rsp_data_b; end
      load_en = mid_ld && (k == 1); load_addr = a; load_data = ld_d;
      step();
    end
    load_en = 1'b0;
    if (mid_ld) model_load(a, ld_d);
    new_w = word_at(a);
    check({tag, " latency_ws1"}, 32'(lat_a), 32'(exp_lat_a));
    check({tag, " latency_ws3"}, 32'(lat_b), 32'(exp_lat_b));
    // The read edge is edge (latency-1) after accept; the mid load lands on edge 1.
    check({tag, " data_ws1"}, 32'(got_a), 32'((!hit && exp_lat_a - 1 > 1) ? new_w : old_w));
    check({tag, " data_ws3"}, 32'(got_b), 32'((!hit && exp_lat_b - 1 > 1) ? new_w : old_w));
    if (mid_ld) tag_valid = 1'b0;
    else if (!hit) begin tag_valid = 1'b1; tag_addr = a; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nl;
    bit seen;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    tag_valid = 1'b0; tag_addr = '0;

    step(); step();
    rst = 1'b1;
    check("reset req_ready_a", 32'(req_ready_a), 32'd1);
    check("reset req_ready_b", 32'(req_ready_b), 32'd1);
    check("reset rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    check("reset rsp_valid_b", 32'(rsp_valid_b), 32'd0);
    check("reset rsp_data_a", 32'(rsp_data_a), 32'h0000);
    check("reset rsp_data_b", 32'(rsp_data_b), 32'h0000);

    fetch("reset fetch0", 3'd0, 1'b0, 8'h00);

    do_load(3'd2, 8'h34);
    do_load(3'd3, 8'h12);
    fetch("load fetch2", 3'd2, 1'b0, 8'h00);
    check("load fetch2 const", 32'(word_at(3'd2)), 32'h1234);

    req_valid = 1'b1; req_addr = 3'd2; rsp_ready = 1'b0;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 8 && !(rsp_valid_a && rsp_valid_b); k++) step();
    check("bp reach resp_a", 32'(rsp_valid_a), 32'd1);
    check("bp reach resp_b", 32'(rsp_valid_b), 32'd1);
    for (int k = 0; k < 5; k++) begin
      load_en = 1'b1; load_addr = 3'd2; load_data = 8'hFF;
      step();
      check("bp data_a", 32'(rsp_data_a), 32'h1234);
      check("bp data_b", 32'(rsp_data_b), 32'h1234);
      check("bp req_ready_a", 32'(req_ready_a), 32'd0);
      check("bp req_ready_b", 32'(req_ready_b), 32'd0);
      check("bp rsp_valid_a", 32'(rsp_valid_a), 32'd1);
    end
    load_en = 1'b0;
    tag_valid = 1'b1; tag_addr = 3'd2;
    model_load(3'd2, 8'hFF);
    rsp_ready = 1'b1;
    step();
    check("bp release req_ready_a", 32'(req_ready_a), 32'd1);
    check("bp release req_ready_b", 32'(req_ready_b), 32'd1);
    check("bp release rsp_valid_a", 32'(rsp_valid_a), 32'd0);
    check("bp release rsp_valid_b", 32'(rsp_valid_b), 32'd0);

    fetch("after bp fetch2", 3'd2, 1'b0, 8'h00);
    fetch("repeat fetch2", 3'd2, 1'b0, 8'h00);
    do_load(3'd3, 8'h56);
    fetch("reload fetch2", 3'd2, 1'b0, 8'h00);

    do_load(3'd7, 8'hAB);
    do_load(3'd0, 8'hCD);
    fetch("wrap fetch7", 3'd7, 1'b0, 8'h00);
    check("wrap const", 32'(word_at(3'd7)), 32'hCDAB);

    repeat (24) begin
      nl = $urandom_range(0, 2);
      for (int j = 0; j < nl; j++) do_load(3'($urandom_range(0, 7)), 8'($urandom));
      fetch("random", 3'($urandom_range(0, 7)), 1'b0, 8'h00);
    end

    do_load(3'd4, 8'h3C);
    fetch("read-before-write", 3'd4, 1'b1, 8'hC3);

    req_valid = 1'b1; req_addr = 3'd5; rsp_ready = 1'b1;
    step();
    req_valid = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid_a || rsp_valid_b) seen = 1'b1;
      step();
    end
    check("abort no response", 32'(seen), 32'd0);
    for (int i = 0; i < 8; i++) mem_m[i] = 8'h00;
    tag_valid = 1'b0;
    check("abort rsp_data_a", 32'(rsp_data_a), 32'h0000);
    fetch("post-reset fetch5", 3'd5, 1'b0, 8'h00);
    fetch("post-reset fetch2", 3'd2, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
